// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants for the MIPS pipeline control tracker
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int REG_W  = 5;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - generic pipeline register with enable, gated clear and reset value
module pipe_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset wins; a clear only takes effect when the stage is allowed to advance,
    // so a held stage keeps its contents even while a clear is requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= clr ? CLR_VAL : d;
        end
    end

endmodule

// File: rtl/pipe_ctrl_tracker.sv
// rtl/pipe_ctrl_tracker.sv - F..M/W pipeline register bank with hazard-facing taps and CPI counters
module pipe_ctrl_tracker
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    input  logic [31:0]      PCNextF,
    input  logic [31:0]      InstrF,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             RegDstD,
    output logic [31:0]      PCF,
    output logic [31:0]      InstrD,
    output logic [31:0]      PCPlus4D,
    output logic [4:0]       RsD,
    output logic [4:0]       RtD,
    output logic [4:0]       RsE,
    output logic [4:0]       RtE,
    output logic [4:0]       WriteRegE,
    output logic             RegWriteE,
    output logic             MemtoRegE,
    output logic [4:0]       WriteRegM,
    output logic             RegWriteM,
    output logic             MemtoRegM,
    output logic [4:0]       WriteRegW,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic             ValidD,
    output logic             ValidE,
    output logic             ValidM,
    output logic             ValidW,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic [CNT_W-1:0] RetireCount
);

    localparam int FD_W = 32 + 32 + 1;
    localparam int DE_W = 3 * REG_W + 4;
    localparam int XW_W = REG_W + 3;

    localparam logic [FD_W-1:0]  FD_CLR  = {NOP_INSTR, 32'h0, 1'b0};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [REG_W-1:0] RdE;
    logic             RegDstE;

    // Fetch PC: advances unless the hazard unit freezes fetch.
    pipe_reg #(.W(32), .RST_VAL(RESET_PC), .CLR_VAL(RESET_PC)) uPcF (
        .clk   (clk),
        .reset (reset),
        .en    (~StallF),
        .clr   (1'b0),
        .d     (PCNextF),
        .q     (PCF)
    );

    // F/D: a stall takes priority over a branch kill, so the held instruction survives.
    pipe_reg #(.W(FD_W), .RST_VAL(FD_CLR), .CLR_VAL(FD_CLR)) uFd (
        .clk   (clk),
        .reset (reset),
        .en    (~StallD),
        .clr   (FlushD),
        .d     ({InstrF, PCF + 32'd4, 1'b1}),
        .q     ({InstrD, PCPlus4D, ValidD})
    );

    assign RsD = InstrD[RS_LSB +: REG_W];
    assign RtD = InstrD[RT_LSB +: REG_W];

    // D/E: always advances; a flush turns the slot into a bubble with no write-back.
    pipe_reg #(.W(DE_W)) uDe (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (FlushE),
        .d     ({RsD, RtD, InstrD[RD_LSB +: REG_W],
                 RegWriteD & ValidD, MemtoRegD & ValidD, RegDstD, ValidD}),
        .q     ({RsE, RtE, RdE, RegWriteE, MemtoRegE, RegDstE, ValidE})
    );

    assign WriteRegE = RegDstE ? RdE : RtE;

    // E/M: free-running shift of the write-back controls.
    pipe_reg #(.W(XW_W)) uEm (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .d     ({WriteRegE, RegWriteE, MemtoRegE, ValidE}),
        .q     ({WriteRegM, RegWriteM, MemtoRegM, ValidM})
    );

    // M/W: free-running shift of the write-back controls.
    pipe_reg #(.W(XW_W)) uMw (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (1'b0),
        .d     ({WriteRegM, RegWriteM, MemtoRegM, ValidM}),
        .q     ({WriteRegW, RegWriteW, MemtoRegW, ValidW})
    );

    // Saturating CPI counters; a branch kill that loses to a stall is not a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount  <= '0;
            FlushCount  <= '0;
            RetireCount <= '0;
        end else begin
            if ((StallF | StallD) && (StallCount != CNT_MAX)) begin
                StallCount <= StallCount + CNT_ONE;
            end
            if ((FlushE | (FlushD & ~StallD)) && (FlushCount != CNT_MAX)) begin
                FlushCount <= FlushCount + CNT_ONE;
            end
            if (ValidW && (RetireCount != CNT_MAX)) begin
                RetireCount <= RetireCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// tb/tb_pipe_ctrl_tracker.sv - scoreboard bench for pipe_ctrl_tracker
module tb_pipe_ctrl_tracker;

    localparam logic [31:0] RPC   = 32'h0040_0000;
    localparam int          CW    = 4;
    localparam int          CMAX  = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, FlushE = 1'b0;
    logic [31:0] PCNextF = '0, InstrF = '0;
    logic        RegWriteD = 1'b0, MemtoRegD = 1'b0, RegDstD = 1'b0;

    logic [31:0] PCF, InstrD, PCPlus4D;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW, MemtoRegW;
    logic        ValidD, ValidE, ValidM, ValidW;
    logic [CW-1:0] StallCount, FlushCount, RetireCount;

    pipe_ctrl_tracker #(.RESET_PC(RPC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .FlushE(FlushE), .PCNextF(PCNextF), .InstrF(InstrF), .RegWriteD(RegWriteD),
        .MemtoRegD(MemtoRegD), .RegDstD(RegDstD), .PCF(PCF), .InstrD(InstrD),
        .PCPlus4D(PCPlus4D), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ValidD(ValidD), .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW),
        .StallCount(StallCount), .FlushCount(FlushCount), .RetireCount(RetireCount)
    );

    always #5 clk = ~clk;

    // An instruction past decode, described by what it means rather than by register fields.
    typedef struct {
        bit       valid;
        bit [4:0] rs, rt, dest;
        bit       writes, loads;
    } slot_t;

    typedef struct {
        bit [31:0] pcf, instr, pc4;
        bit        vD;
        slot_t     e, m, w;
        int        stalls, flushes, retires;
    } snap_t;

    typedef struct { bit [4:0] dest; bit writes; } ret_t;

    snap_t expQ[$];
    ret_t  retQ[$];

    // Reference model state.
    bit [31:0] mPc, mInstr, mPc4;
    bit        mVD;
    slot_t     mStage[3];
    int        mStalls, mFlushes, mRetires;

    int checks = 0;
    int failures = 0;
    bit done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int satInc(int v, bit cond);
        return (cond && v < CMAX) ? v + 1 : v;
    endfunction

    function automatic bit [31:0] mkInstr(bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, 6'h20};
    endfunction

    // Drive one cycle of inputs, advance the model, and queue what the DUT must show after the edge.
    task automatic step(input bit rst, input bit sf, input bit sd, input bit fd, input bit fe,
                        input bit [31:0] instr, input bit rw, input bit rdst);
        slot_t  entering;
        snap_t  s;
        bit     mtr;
        bit [4:0] rd;
        @(negedge clk);
        mtr       = 1'($urandom_range(0, 1));
        reset     = rst;
        StallF    = sf;
        StallD    = sd;
        FlushD    = fd;
        FlushE    = fe;
        PCNextF   = $urandom;
        InstrF    = instr;
        RegWriteD = rw;
        MemtoRegD = mtr;
        RegDstD   = rdst;
        if (rst) begin
            mPc = RPC; mInstr = 0; mPc4 = 0; mVD = 0;
            for (int i = 0; i < 3; i++) mStage[i] = '{default: 0};
            mStalls = 0; mFlushes = 0; mRetires = 0;
        end else begin
            entering = '{default: 0};
            if (!fe) begin
                rd              = mInstr[15:11];
                entering.valid  = mVD;
                entering.rs     = mInstr[25:21];
                entering.rt     = mInstr[20:16];
                entering.dest   = rdst ? rd : mInstr[20:16];
                entering.writes = rw && mVD;
                entering.loads  = mtr && mVD;
            end
            mStalls  = satInc(mStalls, sf || sd);
            mFlushes = satInc(mFlushes, fe || (fd && !sd));
            mRetires = satInc(mRetires, mStage[2].valid);
            mStage[2] = mStage[1];
            mStage[1] = mStage[0];
            mStage[0] = entering;
            if (!sd) begin
                if (fd) begin
                    mInstr = 0; mPc4 = 0; mVD = 0;
                end else begin
                    mInstr = instr; mPc4 = mPc + 32'd4; mVD = 1;
                end
            end
            if (!sf) mPc = PCNextF;
            if (mStage[2].valid) retQ.push_back('{dest: mStage[2].dest, writes: mStage[2].writes});
        end
        s.pcf = mPc; s.instr = mInstr; s.pc4 = mPc4; s.vD = mVD;
        s.e = mStage[0]; s.m = mStage[1]; s.w = mStage[2];
        s.stalls = mStalls; s.flushes = mFlushes; s.retires = mRetires;
        expQ.push_back(s);
    endtask

    // Monitor: after each edge, compare the DUT against the oldest queued expectation.
    initial begin
        snap_t e;
        ret_t  r;
        while (!done) begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("PCF", PCF, e.pcf);
                chk("InstrD", InstrD, e.instr);
                chk("PCPlus4D", PCPlus4D, e.pc4);
                chk("RsD", {27'd0, RsD}, {27'd0, e.instr[25:21]});
                chk("RtD", {27'd0, RtD}, {27'd0, e.instr[20:16]});
                chk("ValidD", {31'd0, ValidD}, {31'd0, e.vD});
                chk("ValidE", {31'd0, ValidE}, {31'd0, e.e.valid});
                chk("RsE", {27'd0, RsE}, {27'd0, e.e.rs});
                chk("RtE", {27'd0, RtE}, {27'd0, e.e.rt});
                chk("WriteRegE", {27'd0, WriteRegE}, {27'd0, e.e.dest});
                chk("RegWriteE", {31'd0, RegWriteE}, {31'd0, e.e.writes});
                chk("MemtoRegE", {31'd0, MemtoRegE}, {31'd0, e.e.loads});
                chk("ValidM", {31'd0, ValidM}, {31'd0, e.m.valid});
                chk("WriteRegM", {27'd0, WriteRegM}, {27'd0, e.m.dest});
                chk("RegWriteM", {31'd0, RegWriteM}, {31'd0, e.m.writes});
                chk("MemtoRegM", {31'd0, MemtoRegM}, {31'd0, e.m.loads});
                chk("ValidW", {31'd0, ValidW}, {31'd0, e.w.valid});
                chk("MemtoRegW", {31'd0, MemtoRegW}, {31'd0, e.w.loads});
                chk("StallCount", {28'd0, StallCount}, e.stalls);
                chk("FlushCount", {28'd0, FlushCount}, e.flushes);
                chk("RetireCount", {28'd0, RetireCount}, e.retires);
            end
            if (ValidW === 1'b1) begin
                if (retQ.size() == 0) begin
                    chk("retire_unexpected", 32'd1, 32'd0);
                end else begin
                    r = retQ.pop_front();
                    chk("retire_WriteRegW", {27'd0, WriteRegW}, {27'd0, r.dest});
                    chk("retire_RegWriteW", {31'd0, RegWriteW}, {31'd0, r.writes});
                end
            end
        end
    end

    // Stimulus: reset, straight-line code, random hazards, stall saturation, reset mid-stream.
    initial begin
        int r;
        bit sf, sd, fd, fe;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 0, 0, mkInstr(5'd8, 5'd3, 5'(8 + i)), 1, 1);

        for (int n = 0; n < 800; n++) begin
            r  = $urandom_range(0, 99);
            sf = 0; sd = 0; fd = 0; fe = ($urandom_range(0, 9) == 0);
            if (r < 10)      begin sf = 1; sd = 1; fe = 1; end
            else if (r < 16) begin sd = 1; fd = 1; end
            else if (r < 26) begin fd = 1; end
            else if (r < 34) begin sf = 1; end
            step(r >= 97, sf, sd, fd, fe,
                 mkInstr(5'($urandom), 5'($urandom), 5'($urandom)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 20; i++)
            step(0, 1, 0, 0, 0, mkInstr(5'd1, 5'd2, 5'd3), 1, 1);
        @(posedge clk);
        #2;
        chk("stall_saturated", {28'd0, StallCount}, CMAX);

        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, mkInstr(5'd4, 5'd5, 5'd6), 1, 0);
        step(1, 0, 0, 0, 0, mkInstr(5'd4, 5'd5, 5'd6), 1, 0);
        step(0, 0, 0, 0, 0, mkInstr(5'd4, 5'd5, 5'd6), 1, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drain", expQ.size(), 0);
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_tracker.md
Name: pipe_ctrl_tracker

Overview:
- Pipeline-register bank for the 5-stage MIPS core, covering F, F/D, D/E, E/M and M/W. It consumes the hazard unit's StallF, StallD and FlushE controls, plus the branch flush FlushD.
- Carries instruction, register specifiers and write-back control through the stages. Produces every stage signal the hazard unit reads: RsD/RtD/RsE/RtE, WriteReg*/RegWrite*/MemtoReg*.
- Keeps saturating stall, flush and retire counters for CPI debug.

Parameters:
- RESET_PC, 32'h0000_0000, value PCF takes on reset.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- StallF  in  1  hold PCF
- StallD  in  1  hold F/D register
- FlushD  in  1  branch taken in D; kill F/D contents
- FlushE  in  1  insert bubble into D/E
- PCNextF  in  32  next PC from fetch mux
- InstrF  in  32  instruction memory output
- RegWriteD, MemtoRegD, RegDstD  in  1 each  decoder controls for InstrD
- PCF  out  32  current fetch PC
- InstrD  out  32  decode-stage instruction
- PCPlus4D  out  32  PC+4 of InstrD
- RsD, RtD  out  5 each  InstrD[25:21], InstrD[20:16]
- RsE, RtE, WriteRegE  out  5 each  E-stage specifiers; WriteRegE = RegDstE ? RdE : RtE
- RegWriteE, MemtoRegE  out  1 each
- WriteRegM  out  5;  RegWriteM, MemtoRegM  out  1 each
- WriteRegW  out  5;  RegWriteW, MemtoRegW  out  1 each
- ValidD, ValidE, ValidM, ValidW  out  1 each  stage holds a real instruction
- StallCount, FlushCount, RetireCount  out  CNT_W each

Behaviour:
- Reset (synchronous, dominates every other input that cycle):
  - PCF = RESET_PC.
  - All other registers and outputs = 0; InstrD = NOP (32'h0).
  - All counters = 0.
- F, each edge: if !StallF then PCF <= PCNextF, else hold.
- F/D, priority StallD > FlushD > load:
  - StallD: hold InstrD, PCPlus4D and ValidD, even when FlushD = 1.
  - FlushD: InstrD <= NOP, ValidD <= 0, PCPlus4D <= 0.
  - Otherwise: InstrD <= InstrF, PCPlus4D <= PCF + 4 (mod 2^32, wraps at 32'hFFFF_FFFC), ValidD <= 1.
- D/E (no stall input):
  - FlushE: RegWriteE, MemtoRegE, RegDstE, ValidE, RsE, RtE, RdE all <= 0.
  - Otherwise: RsE/RtE/RdE <= InstrD fields; RegWriteE <= RegWriteD & ValidD; MemtoRegE <= MemtoRegD & ValidD; RegDstE <= RegDstD; ValidE <= ValidD.
  - A flushed or invalid slot never asserts RegWrite, so the hazard unit never forwards from a bubble.
- E/M and M/W advance every cycle with no enable or clear: WriteReg, RegWrite, MemtoReg and Valid each shift one stage.
- Latency: an instruction loaded into F/D at edge n reaches W at edge n+3, given no stall or flush.
- Counters, all saturating at 2^CNT_W−1 and never wrapping:
  - StallCount += 1 when StallF | StallD.
  - FlushCount += 1 when FlushE | (FlushD & !StallD). One increment per cycle even if both are true.
  - RetireCount += 1 when ValidW.
- Simultaneous StallD and FlushE (load-use stall): D holds and E gets a bubble, both in the same edge. This is the required load-use behaviour.
- All outputs are registered, except:
  - RsD, RtD: combinational slices of InstrD.
  - WriteRegE: combinational mux of registered fields.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR = 32'h0.
  - Field LSB constants RS_LSB = 21, RT_LSB = 16, RD_LSB = 11; REG_W = 5.
  - RESET_PC default.
- One natural sub-module, pipe_reg: parameterised width, inputs en and clr, synchronous reset value parameter, clr gated by en as specified above. Instantiated once per stage register group.

Test Plan:
- Reset: hold reset 2 cycles with RESET_PC = 32'h0040_0000 → PCF = 32'h0040_0000; all Valid* = 0; all counters = 0; InstrD = 0.
- Straight line: feed 4 instructions, each RegWriteD = 1, RegDstD = 1, Rd = 8..11, no stalls → WriteRegW = 8,9,10,11 on consecutive cycles starting 3 cycles after the first F/D load; RetireCount = 4.
- Load-use: assert StallF = StallD = FlushE for 1 cycle while InstrD = add $9,$8,$x → PCF and InstrD unchanged; next cycle RegWriteE = 0 and ValidE = 0; StallCount = 1, FlushCount = 1; add reaches E one cycle later with RsE = 8.
- Branch flush: FlushD = 1, StallD = 0 → InstrD = 0 and ValidD = 0 next cycle; that slot yields RegWriteW = 0 three cycles later; RetireCount does not count it.
- StallD + FlushD together → InstrD held unchanged; FlushCount not incremented by FlushD.
- Counter saturation with CNT_W = 4: hold StallF for 20 cycles → StallCount stops at 15. Then assert reset mid-stream while ValidE = 1 → next cycle all Valid* = 0 and counters = 0.
